ysyx_25030081_wbu: RTL and testbench

//  Writeback unit: the writer side of the register file write port. Accepts results from
//  EXU (ALU) and LSU over valid/ready, queues them in a small FIFO, drives one register-file

---
 rtl/ysyx_25030081_wbu.sv | 152 +++++++++++++++
 tb/tb_ysyx_25030081_wbu.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25030081_wbu.sv
// Writeback unit: queues ALU/LSU results, drives one register-file write per cycle and keeps a
// pending-destination scoreboard for IDU hazards. Optional perf counters under WBU_PERF_EN.
module ysyx_25030081_wbu #(
    parameter int unsigned RF_ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [RF_ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0]    alu_data,
    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [RF_ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0]    lsu_data,
    input  logic                     wb_stall,
    input  logic                     issue_en,
    input  logic [RF_ADDR_WIDTH-1:0] issue_rd,
    input  logic [RF_ADDR_WIDTH-1:0] rs1,
    input  logic [RF_ADDR_WIDTH-1:0] rs2,
    output logic                     hazard,
    output logic                     rf_wen,
    output logic [RF_ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0]    rf_wdata
`ifdef WBU_PERF_EN
    ,
    output logic [31:0]              wb_cnt,
    output logic [31:0]              bp_cnt
`endif
);

    localparam int unsigned NumRegs = 1 << RF_ADDR_WIDTH;
    localparam int unsigned IdxW    = $clog2(FIFO_DEPTH);
    localparam int unsigned PtrW    = IdxW + 1;

    typedef struct packed {
        logic [RF_ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]    data;
    } entry_t;

    entry_t                   mem_q [FIFO_DEPTH];
    entry_t                   enq_entry;
    logic [PtrW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]          rd_ptr_q, rd_ptr_d;
    logic                     slot_valid_q, slot_valid_d;
    logic [RF_ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [NumRegs-1:0]       pending_q, pending_d;

    logic fifo_empty, fifo_full;
    logic lsu_fire, alu_fire, enq, deq, slot_done;

    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[IdxW] != rd_ptr_q[IdxW]) &&
                     (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]);

        // LSU has fixed priority; at most one enqueue per cycle.
        lsu_ready = rst_n && !fifo_full;
        alu_ready = rst_n && !fifo_full && !lsu_valid;
        lsu_fire  = lsu_valid && lsu_ready;
        alu_fire  = alu_valid && alu_ready;
        enq       = lsu_fire || alu_fire;

        enq_entry.rd   = lsu_fire ? lsu_rd : alu_rd;
        enq_entry.data = lsu_fire ? lsu_data : alu_data;

        // Slot retires (written or, for x0, dropped) whenever not stalled.
        slot_done = slot_valid_q && !wb_stall;
        deq       = (!slot_valid_q || slot_done) && !wb_stall && !fifo_empty;

        rf_wen   = rst_n && slot_done && (waddr_q != '0);
        rf_waddr = waddr_q;
        rf_wdata = wdata_q;

        wr_ptr_d = enq ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = deq ? rd_ptr_q + PtrW'(1) : rd_ptr_q;

        slot_valid_d = slot_valid_q;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        if (deq) begin
            slot_valid_d = 1'b1;
            waddr_d      = mem_q[rd_ptr_q[IdxW-1:0]].rd;
            wdata_d      = mem_q[rd_ptr_q[IdxW-1:0]].data;
        end else if (slot_done) begin
            slot_valid_d = 1'b0;
        end

        // Clear first so a same-cycle issue to the same index wins.
        pending_d = pending_q;
        if (rf_wen) begin
            pending_d[waddr_q] = 1'b0;
        end
        if (issue_en && (issue_rd != '0)) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;

        hazard = pending_q[rs1] | pending_q[rs2] | pending_q[issue_rd];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            slot_valid_q <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            pending_q    <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            slot_valid_q <= slot_valid_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            pending_q    <= pending_d;
        end
    end

    // Storage is qualified by the pointers, so it needs no reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_q[wr_ptr_q[IdxW-1:0]] <= enq_entry;
        end
    end

`ifdef WBU_PERF_EN
    logic [31:0] wb_cnt_q, wb_cnt_d;
    logic [31:0] bp_cnt_q, bp_cnt_d;

    always_comb begin
        wb_cnt_d = wb_cnt_q + {31'd0, rf_wen};
        bp_cnt_d = bp_cnt_q + {31'd0, (alu_valid && !alu_ready) || (lsu_valid && !lsu_ready)};
        wb_cnt   = wb_cnt_q;
        bp_cnt   = bp_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_cnt_q <= '0;
            bp_cnt_q <= '0;
        end else begin
            wb_cnt_q <= wb_cnt_d;
            bp_cnt_q <= bp_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_25030081_wbu.sv
// Bench for ysyx_25030081_wbu: directed scenarios plus randomized traffic checked every cycle
// against a queue-based reference model of the writeback path and scoreboard.
module tb_ysyx_25030081_wbu;

    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b1;
    logic          rst_n = 1'b0;
    logic          alu_valid = 1'b0, lsu_valid = 1'b0;
    logic          alu_ready, lsu_ready;
    logic [AW-1:0] alu_rd = '0, lsu_rd = '0;
    logic [DW-1:0] alu_data = '0, lsu_data = '0;
    logic          wb_stall = 1'b0, issue_en = 1'b0;
    logic [AW-1:0] issue_rd = '0, rs1 = '0, rs2 = '0;
    logic          hazard, rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
`ifdef WBU_PERF_EN
    logic [31:0]   wb_cnt, bp_cnt;
`endif

    always #5 clk = ~clk;

    ysyx_25030081_wbu #(
        .RF_ADDR_WIDTH(AW),
        .DATA_WIDTH   (DW),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .alu_valid(alu_valid),
        .alu_ready(alu_ready),
        .alu_rd   (alu_rd),
        .alu_data (alu_data),
        .lsu_valid(lsu_valid),
        .lsu_ready(lsu_ready),
        .lsu_rd   (lsu_rd),
        .lsu_data (lsu_data),
        .wb_stall (wb_stall),
        .issue_en (issue_en),
        .issue_rd (issue_rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .hazard   (hazard),
        .rf_wen   (rf_wen),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata)
`ifdef WBU_PERF_EN
        ,
        .wb_cnt   (wb_cnt),
        .bp_cnt   (bp_cnt)
`endif
    );

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } entry_t;

    // Reference model: results accepted but not yet in the writeback slot, then the slot itself.
    entry_t     q_m[$];
    logic       slot_v_m = 1'b0;
    entry_t     slot_m = '0;
    logic [31:0] pend_m = '0;
    bit         seen_reset = 1'b0;
    bit         alu_hold_m = 1'b0, lsu_hold_m = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_hazard(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                          input logic [AW-1:0] c);
        return pend_m[a] | pend_m[b] | pend_m[c];
    endfunction

    task automatic model_check();
        logic full, exp_lr, exp_ar, exp_wen;
        full    = (q_m.size() >= DEPTH);
        exp_lr  = rst_n && !full;
        exp_ar  = exp_lr && !lsu_valid;
        exp_wen = rst_n && slot_v_m && !wb_stall && (slot_m.rd != '0);
        check_eq("m_lsu_ready", 64'(lsu_ready), 64'(exp_lr));
        check_eq("m_alu_ready", 64'(alu_ready), 64'(exp_ar));
        check_eq("m_rf_wen", 64'(rf_wen), 64'(exp_wen));
        if (exp_wen) begin
            check_eq("m_rf_waddr", 64'(rf_waddr), 64'(slot_m.rd));
            check_eq("m_rf_wdata", 64'(rf_wdata), 64'(slot_m.data));
        end
        if (seen_reset && rst_n) begin
            check_eq("m_hazard", 64'(hazard), 64'(model_hazard(rs1, rs2, issue_rd)));
        end
    endtask

    task automatic model_advance();
        logic full, lr, ar, retire, load;
        if (!rst_n) begin
            q_m.delete();
            slot_v_m   = 1'b0;
            slot_m     = '0;
            pend_m     = '0;
            seen_reset = 1'b1;
            alu_hold_m = 1'b0;
            lsu_hold_m = 1'b0;
            return;
        end
        full   = (q_m.size() >= DEPTH);
        lr     = !full;
        ar     = !full && !lsu_valid;
        retire = slot_v_m && !wb_stall;
        if (retire && slot_m.rd != '0) pend_m[slot_m.rd] = 1'b0;
        if (issue_en && issue_rd != '0) pend_m[issue_rd] = 1'b1;
        load = (!slot_v_m || retire) && !wb_stall && (q_m.size() > 0);
        if (load) begin
            slot_m   = q_m.pop_front();
            slot_v_m = 1'b1;
        end else if (retire) begin
            slot_v_m = 1'b0;
        end
        if (lsu_valid && lr) q_m.push_back('{rd: lsu_rd, data: lsu_data});
        else if (alu_valid && ar) q_m.push_back('{rd: alu_rd, data: alu_data});
        alu_hold_m = alu_valid && !ar;
        lsu_hold_m = lsu_valid && !lr;
    endtask

    task automatic step();
        @(negedge clk);
        model_check();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        wb_stall  = 1'b0;
        issue_en  = 1'b0;
        issue_rd  = '0;
        rs1       = '0;
        rs2       = '0;
    endtask

    initial begin
        // 1: reset with both producers valid
        rst_n = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h2;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("t1_alu_ready", 64'(alu_ready), 64'(0));
            check_eq("t1_lsu_ready", 64'(lsu_ready), 64'(0));
            check_eq("t1_rf_wen", 64'(rf_wen), 64'(0));
            step();
        end
        rst_n = 1'b1;
        idle();
        rs1 = 5'd5; rs2 = 5'd6; issue_rd = 5'd7;
        #1;
        check_eq("t1_hazard", 64'(hazard), 64'(0));
        check_eq("t1_waddr", 64'(rf_waddr), 64'(0));
        check_eq("t1_wdata", 64'(rf_wdata), 64'(0));
        check_eq("t1_rf_wen_post", 64'(rf_wen), 64'(0));
        step();

        // 2: issue x5, then ALU result to x5
        idle(); issue_en = 1'b1; issue_rd = 5'd5;
        step();
        issue_en = 1'b0; rs1 = 5'd5;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        check_eq("t2_ready_c0", 64'(alu_ready), 64'(1));
        check_eq("t2_wen_c0", 64'(rf_wen), 64'(0));
        check_eq("t2_haz_c0", 64'(hazard), 64'(1));
        step();
        alu_valid = 1'b0;
        #1;
        check_eq("t2_wen_c1", 64'(rf_wen), 64'(0));
        check_eq("t2_haz_c1", 64'(hazard), 64'(1));
        step();
        check_eq("t2_wen_c2", 64'(rf_wen), 64'(1));
        check_eq("t2_waddr_c2", 64'(rf_waddr), 64'(5));
        check_eq("t2_wdata_c2", 64'(rf_wdata), 64'(32'hDEADBEEF));
        check_eq("t2_haz_c2", 64'(hazard), 64'(1));
        step();
        check_eq("t2_wen_c3", 64'(rf_wen), 64'(0));
        check_eq("t2_haz_c3", 64'(hazard), 64'(0));
        step();

        // 3: LSU priority over ALU
        idle();
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h44;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
        #1;
        check_eq("t3_alu_ready_c0", 64'(alu_ready), 64'(0));
        check_eq("t3_lsu_ready_c0", 64'(lsu_ready), 64'(1));
        step();
        lsu_valid = 1'b0;
        #1;
        check_eq("t3_alu_ready_c1", 64'(alu_ready), 64'(1));
        step();
        alu_valid = 1'b0;
        #1;
        check_eq("t3_wen_c2", 64'(rf_wen), 64'(1));
        check_eq("t3_waddr_c2", 64'(rf_waddr), 64'(4));
        check_eq("t3_wdata_c2", 64'(rf_wdata), 64'(32'h44));
        step();
        check_eq("t3_wen_c3", 64'(rf_wen), 64'(1));
        check_eq("t3_waddr_c3", 64'(rf_waddr), 64'(3));
        check_eq("t3_wdata_c3", 64'(rf_wdata), 64'(32'h33));
        step();
        step();

        // 4: stall fills the queue, release drains in order
        idle(); wb_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            alu_valid = 1'b1; alu_rd = 5'(10 + i); alu_data = 32'hA000_0000 + 32'(i);
            #1;
            check_eq("t4_ready_fill", 64'(alu_ready), 64'(i < 4 ? 1 : 0));
            check_eq("t4_wen_stall", 64'(rf_wen), 64'(0));
            step();
        end
        check_eq("t4_ready_held", 64'(alu_ready), 64'(0));
        check_eq("t4_wen_held", 64'(rf_wen), 64'(0));
        step();
        wb_stall = 1'b0;
        #1;
        check_eq("t4_ready_rel", 64'(alu_ready), 64'(0));
        check_eq("t4_wen_rel", 64'(rf_wen), 64'(0));
        step();
        check_eq("t4_ready_acc", 64'(alu_ready), 64'(1));
        for (int i = 0; i < 5; i++) begin
            if (i == 1) alu_valid = 1'b0;
            #1;
            check_eq("t4_drain_wen", 64'(rf_wen), 64'(1));
            check_eq("t4_drain_addr", 64'(rf_waddr), 64'(10 + i));
            check_eq("t4_drain_data", 64'(rf_wdata), 64'(32'hA000_0000 + 32'(i)));
            step();
        end
        check_eq("t4_wen_end", 64'(rf_wen), 64'(0));
        step();

        // 5: x0 results and issues are invisible
        idle();
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hFFFF_FFFF;
        issue_en = 1'b1; issue_rd = 5'd0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("t5_wen", 64'(rf_wen), 64'(0));
            check_eq("t5_hazard", 64'(hazard), 64'(0));
            step();
            lsu_valid = 1'b0;
        end
        idle();

`ifdef WBU_PERF_EN
        // 6: performance counters
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        lsu_valid = 1'b1; lsu_rd = 5'd1; lsu_data = 32'h11;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
        step();
        lsu_rd = 5'd2; lsu_data = 32'h22;
        step();
        lsu_valid = 1'b0;
        step();
        alu_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check_eq("t6_wb_cnt", 64'(wb_cnt), 64'(3));
        check_eq("t6_bp_cnt", 64'(bp_cnt), 64'(2));
        rst_n = 1'b0;
        step();
        check_eq("t6_wb_cnt_rst", 64'(wb_cnt), 64'(0));
        check_eq("t6_bp_cnt_rst", 64'(bp_cnt), 64'(0));
        rst_n = 1'b1;
        step();
`endif

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if (!lsu_hold_m) begin
                lsu_valid = ($urandom_range(0, 2) == 0);
                lsu_rd    = 5'($urandom_range(0, 7));
                lsu_data  = $urandom();
            end
            if (!alu_hold_m) begin
                alu_valid = ($urandom_range(0, 1) == 1);
                alu_rd    = 5'($urandom_range(0, 7));
                alu_data  = $urandom();
            end
            wb_stall = ($urandom_range(0, 4) == 0);
            rs1      = 5'($urandom_range(0, 7));
            rs2      = 5'($urandom_range(0, 7));
            issue_rd = 5'($urandom_range(0, 7));
            issue_en = ($urandom_range(0, 1) == 1) && !model_hazard(rs1, rs2, issue_rd);
            step();
        end
        idle();
        for (int i = 0; i < 8; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
